// File: rtl/tw_buf_param_pkg.sv
// Shared types and constants for the twiddle-factor buffer.
// No logic; compile before every other tw_buf file.
// Supplies UNITY, the sequencer state encoding and the half-select codes.
package tw_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  // ld_half encoding: 0 targets [P_WIDTH-1:DW], 1 targets [DW-1:0]
  localparam logic HALF_HI = 1'b0;
  localparam logic HALF_LO = 1'b1;

  localparam int UNITY_MAX_W = 256;

  // Multiplicative identity in both modulus lanes: {DW'd1, DW'd1}.
  // Callers truncate the result to 2*dw bits.
  function automatic logic [UNITY_MAX_W-1:0] unity(input int dw);
    return UNITY_MAX_W'(1) | (UNITY_MAX_W'(1) << dw);
  endfunction

endpackage

// File: rtl/tw_buf_param_if.sv
// Load port and read-side bus of the twiddle buffer.
// Pure wiring, no latency.
// Load uses ld_valid/ld_ready; the read side has no backpressure. Optional bp_valid under TW_BYPASS_EN.
interface tw_buf_param_if #(
  parameter int DW     = 64,
  parameter int NSTAGE = 4,
  parameter int NGROUP = 4,
  parameter int DEPTH  = 4
);
  localparam int P_WIDTH  = 2 * DW;
  localparam int SC_WIDTH = $clog2(NSTAGE) + 1;
  localparam int GW       = $clog2(NGROUP);
  localparam int IW       = $clog2(DEPTH);

  // read side
  logic                CEN;
  logic [SC_WIDTH-1:0] stage_counter;
  logic                run;
  logic [P_WIDTH-1:0]  Q;
  logic                Q_valid;
  logic [P_WIDTH-1:0]  Q_const;
  logic                err;
`ifdef TW_BYPASS_EN
  logic                bp_valid;
`endif

  // load side
  logic                ld_valid;
  logic                ld_ready;
  logic                ld_const;
  logic [SC_WIDTH-1:0] ld_stage;
  logic [GW-1:0]       ld_group;
  logic [IW-1:0]       ld_idx;
  logic                ld_half;
  logic [DW-1:0]       ld_data;

  modport master (
    output CEN, stage_counter, run,
    output ld_valid, ld_const, ld_stage, ld_group, ld_idx, ld_half, ld_data,
`ifdef TW_BYPASS_EN
    input  bp_valid,
`endif
    input  ld_ready, Q, Q_valid, Q_const, err
  );

  modport slave (
    input  CEN, stage_counter, run,
    input  ld_valid, ld_const, ld_stage, ld_group, ld_idx, ld_half, ld_data,
`ifdef TW_BYPASS_EN
    output bp_valid,
`endif
    output ld_ready, Q, Q_valid, Q_const, err
  );

endinterface

// File: rtl/tw_buf_param_rd_seq.sv
// Read sequencer: idx/rep/grp counters with group rotation and stage-change restart.
// Read address is combinational from the sampled inputs; q_vld is registered (1 cycle).
// No backpressure; CEN high parks the sequencer in IDLE with the counters held.
module tw_rd_seq
  import tw_buf_pkg::*;
#(
  parameter int NSTAGE   = 4,
  parameter int NGROUP   = 4,
  parameter int DEPTH    = 4,
  parameter int REP      = 16,
  parameter int SC_WIDTH = $clog2(NSTAGE) + 1
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       CEN,
  input  logic                       run,
  input  logic [SC_WIDTH-1:0]        stage_counter,
  output logic [$clog2(NGROUP)-1:0]  rd_grp,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_en,
  output logic                       q_vld
);
  localparam int GW = $clog2(NGROUP);
  localparam int IW = $clog2(DEPTH);
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [SC_WIDTH-1:0] NST = SC_WIDTH'(NSTAGE);

  seq_state_t          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, idx_e;
  logic [GW-1:0]       grp_q, grp_d, grp_e;
  logic [RW-1:0]       rep_q, rep_d, rep_e;
  logic [SC_WIDTH-1:0] sc_q;
  logic                in_range, stage_chg;

  assign in_range  = stage_counter < NST;
  assign stage_chg = !CEN && (stage_counter != sc_q);
  assign rd_grp    = grp_e;
  assign rd_idx    = idx_e;
  assign q_vld     = (state_q == READ);

  // State, counters and the stage copy used for change detection
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      grp_q   <= '0;
      rep_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grp_q   <= grp_d;
      rep_q   <= rep_d;
      if (!CEN) sc_q <= stage_counter;
    end
  end

  // Next state, effective read address and counter advance
  always_comb begin
    state_d = IDLE;
    rd_en   = 1'b0;
    idx_e   = idx_q;
    grp_e   = grp_q;
    rep_e   = rep_q;
    idx_d   = idx_q;
    grp_d   = grp_q;
    rep_d   = rep_q;

    // out-of-range stage is treated as a pause with everything cleared
    if (!CEN) state_d = (run && in_range) ? READ : PAUSE;

    // a new stage (or an invalid one) restarts at group 0, index 0
    if (stage_chg || (!CEN && !in_range)) begin
      idx_e = '0;
      grp_e = '0;
      rep_e = '0;
    end

    case (state_d)
      READ: begin
        rd_en = 1'b1;
        grp_d = grp_e;
        rep_d = rep_e;
        if (idx_e == IW'(DEPTH - 1)) begin
          idx_d = '0;
          if (rep_e == RW'(REP - 1)) begin
            rep_d = '0;
            grp_d = (grp_e == GW'(NGROUP - 1)) ? '0 : grp_e + GW'(1);
          end else begin
            rep_d = rep_e + RW'(1);
          end
        end else begin
          idx_d = idx_e + IW'(1);
        end
      end
      PAUSE: begin
        idx_d = '0;
        grp_d = grp_e;
        rep_d = rep_e;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tw_buf_param.sv
// Run-time-loadable twiddle buffer (NSTAGE x NGROUP x DEPTH words) with sequenced read and stage constant.
// Q/Q_valid/Q_const are registered: 1 cycle after the sampled CEN/run/stage_counter.
// Loads accepted only while CEN=1 (ld_ready = CEN); TW_BYPASS_EN adds a 1-cycle load echo on Q with bp_valid.
module tw_buf_param
  import tw_buf_pkg::*;
#(
  parameter int DW     = 64,
  parameter int NSTAGE = 4,
  parameter int NGROUP = 4,
  parameter int DEPTH  = 4,
  parameter int REP    = 16
) (
  input  logic           CLK,
  input  logic           rst_n,
  tw_buf_param_if.slave  bus
);
  localparam int P_WIDTH  = 2 * DW;
  localparam int SC_WIDTH = $clog2(NSTAGE) + 1;
  localparam int ST_W     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam int GW       = $clog2(NGROUP);
  localparam int IW       = $clog2(DEPTH);
  localparam logic [SC_WIDTH-1:0] NST   = SC_WIDTH'(NSTAGE);
  localparam logic [P_WIDTH-1:0]  UNITY = P_WIDTH'(unity(DW));

  logic [P_WIDTH-1:0] mem [NSTAGE][NGROUP][DEPTH];
  logic [P_WIDTH-1:0] cst [NSTAGE];

  logic            ld_acc, ld_ok, sc_ok;
  logic [ST_W-1:0] ld_s, sc_s;
  logic [GW-1:0]   rd_grp;
  logic [IW-1:0]   rd_idx;
  logic            rd_en, q_vld;

  assign bus.ld_ready = bus.CEN;
  assign ld_acc       = bus.ld_valid & bus.CEN;
  assign ld_ok        = bus.ld_stage < NST;
  assign sc_ok        = bus.stage_counter < NST;
  assign ld_s         = bus.ld_stage[ST_W-1:0];
  assign sc_s         = bus.stage_counter[ST_W-1:0];
  assign bus.Q_valid  = q_vld;

  tw_rd_seq #(
    .NSTAGE  (NSTAGE),
    .NGROUP  (NGROUP),
    .DEPTH   (DEPTH),
    .REP     (REP),
    .SC_WIDTH(SC_WIDTH)
  ) u_seq (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .CEN          (bus.CEN),
    .run          (bus.run),
    .stage_counter(bus.stage_counter),
    .rd_grp       (rd_grp),
    .rd_idx       (rd_idx),
    .rd_en        (rd_en),
    .q_vld        (q_vld)
  );

  // Storage: reset to UNITY, half-word writes from the loader
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSTAGE; s++) begin
        cst[s] <= UNITY;
        for (int g = 0; g < NGROUP; g++)
          for (int i = 0; i < DEPTH; i++)
            mem[s][g][i] <= UNITY;
      end
    end else if (ld_acc && ld_ok) begin
      if (bus.ld_const) begin
        if (bus.ld_half == HALF_HI) cst[ld_s][P_WIDTH-1:DW] <= bus.ld_data;
        else                        cst[ld_s][DW-1:0]       <= bus.ld_data;
      end else begin
        if (bus.ld_half == HALF_HI) mem[ld_s][bus.ld_group][bus.ld_idx][P_WIDTH-1:DW] <= bus.ld_data;
        else                        mem[ld_s][bus.ld_group][bus.ld_idx][DW-1:0]       <= bus.ld_data;
      end
    end
  end

  // Sticky error on a load addressed past the last stage
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                bus.err <= 1'b0;
    else if (ld_acc && !ld_ok) bus.err <= 1'b1;
  end

`ifdef TW_BYPASS_EN
  logic               echo_en;
  logic [P_WIDTH-1:0] echo_word;
  assign echo_en   = ld_acc && !bus.ld_const;
  assign echo_word = (bus.ld_half == HALF_HI) ? {bus.ld_data, {DW{1'b0}}}
                                              : {{DW{1'b0}}, bus.ld_data};
`endif

  // Output word: load echo first, then sequenced read, otherwise UNITY
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.Q <= UNITY;
`ifdef TW_BYPASS_EN
      bus.bp_valid <= 1'b0;
`endif
    end else begin
`ifdef TW_BYPASS_EN
      bus.bp_valid <= echo_en;
      if (echo_en)    bus.Q <= echo_word;
      else if (rd_en) bus.Q <= mem[sc_s][rd_grp][rd_idx];
      else            bus.Q <= UNITY;
`else
      if (rd_en) bus.Q <= mem[sc_s][rd_grp][rd_idx];
      else       bus.Q <= UNITY;
`endif
    end
  end

  // Stage constant follows the selected stage while reading is enabled
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                   bus.Q_const <= UNITY;
    else if (!bus.CEN && sc_ok)   bus.Q_const <= cst[sc_s];
  end

endmodule

// File: tb/tb_tw_buf_param.sv
// Self-checking bench for tw_buf_param: scoreboard of expected Q words plus direct checks.
// Expected words come from a bench-side copy of the loaded contents and the stated read order.
// Build with +define+TW_BYPASS_EN to also exercise the load echo.
module tb_tw_buf_param;
  import tw_buf_pkg::*;

  localparam int DW = 64, NSTAGE = 4, NGROUP = 4, DEPTH = 4, REP = 16;
  localparam logic [127:0] UNITY = {64'd1, 64'd1};

  logic CLK, rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [127:0] sb[$];
  logic [127:0] exp_w;
  logic [127:0] mdl [NSTAGE][NGROUP][DEPTH];
  logic [127:0] cmdl [NSTAGE];

  tw_buf_param_if #(.DW(DW), .NSTAGE(NSTAGE), .NGROUP(NGROUP), .DEPTH(DEPTH)) bus ();

  tw_buf_param #(.DW(DW), .NSTAGE(NSTAGE), .NGROUP(NGROUP), .DEPTH(DEPTH), .REP(REP)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < NSTAGE; s++) begin
      cmdl[s] = UNITY;
      for (int g = 0; g < NGROUP; g++)
        for (int i = 0; i < DEPTH; i++)
          mdl[s][g][i] = UNITY;
    end
  endtask

  function automatic logic [127:0] wv(input int s, input int g, input int i);
    logic [63:0] k;
    k = 64'(s * 16 + g * 4 + i);
    return {64'hC0DE_0000_0000_0000 | k, 64'h5A5A_0000_0000_0000 ^ (k << 8)};
  endfunction

  // One load request held for one edge; model updated only when accepted and in range
  task automatic load(input logic cnst, input int s, input int g, input int i,
                      input logic half, input logic [63:0] d);
    logic         acc;
    logic [127:0] echo;
    bus.ld_valid = 1'b1;
    bus.ld_const = cnst;
    bus.ld_stage = 3'(s);
    bus.ld_group = 2'(g);
    bus.ld_idx   = 2'(i);
    bus.ld_half  = half;
    bus.ld_data  = d;
    acc = bus.CEN;
    #1;
    chk("ld_ready", 128'(bus.ld_ready), 128'(acc));
    tick();
    bus.ld_valid = 1'b0;
    if (acc && s < NSTAGE) begin
      if (cnst) begin
        if (half == HALF_HI) cmdl[s][127:64] = d; else cmdl[s][63:0] = d;
      end else begin
        if (half == HALF_HI) mdl[s][g][i][127:64] = d; else mdl[s][g][i][63:0] = d;
      end
    end
`ifdef TW_BYPASS_EN
    if (acc && !cnst) echo = (half == HALF_HI) ? {d, 64'd0} : {64'd0, d};
    else              echo = UNITY;
    chk("bp_valid", 128'(bus.bp_valid), 128'(acc && !cnst));
`else
    echo = UNITY;
`endif
    chk("ld_q", bus.Q, echo);
    chk("ld_qvalid", 128'(bus.Q_valid), 128'd0);
  endtask

  task automatic load_word(input int s, input int g, input int i, input logic [127:0] w);
    load(1'b0, s, g, i, HALF_HI, w[127:64]);
    load(1'b0, s, g, i, HALF_LO, w[63:0]);
  endtask

  task automatic read_cycle(input logic [127:0] w);
    sb.push_back(w);
    tick();
  endtask

  // Scoreboard: every valid Q must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (rst_n && bus.Q_valid) begin
      if (sb.size() == 0) chk("q_unexpected", 128'(bus.Q_valid), 128'd0);
      else begin
        exp_w = sb.pop_front();
        chk("q_seq", bus.Q, exp_w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mdl_reset();
    rst_n = 1'b1;
    bus.CEN = 1'b1; bus.run = 1'b0; bus.stage_counter = '0;
    bus.ld_valid = 1'b0; bus.ld_const = 1'b0; bus.ld_stage = '0; bus.ld_group = '0;
    bus.ld_idx = '0; bus.ld_half = 1'b0; bus.ld_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_q", bus.Q, UNITY);
    chk("rst_qvalid", 128'(bus.Q_valid), 128'd0);
    chk("rst_qconst", bus.Q_const, UNITY);
    chk("rst_err", 128'(bus.err), 128'd0);
    tick();
    rst_n = 1'b1;

    // reset contents read back as UNITY
    bus.CEN = 1'b0; bus.run = 1'b1; bus.stage_counter = 3'd0;
    for (int c = 0; c < 4; c++) read_cycle(UNITY);
    bus.CEN = 1'b1;
    tick();
    chk("idle_q", bus.Q, UNITY);
    chk("idle_qvalid", 128'(bus.Q_valid), 128'd0);

    // fill stage 1 and part of stage 2, then the named word and a half rewrite
    for (int g = 0; g < NGROUP; g++)
      for (int i = 0; i < DEPTH; i++)
        load_word(1, g, i, wv(1, g, i));
    load_word(2, 0, 0, wv(2, 0, 0));
    load_word(2, 0, 1, wv(2, 0, 1));
    load(1'b0, 1, 0, 2, HALF_HI, 64'hDFFFFFFF00002001);
    load(1'b0, 1, 0, 2, HALF_LO, 64'hAD578F3A5FEEAE66);
    load(1'b0, 1, 1, 3, HALF_HI, 64'hFEED_FACE_0123_4567);
    load(1'b0, 3, 0, 0, HALF_LO, 64'hA5);
    chk("word_1_0_2", mdl[1][0][2], 128'hDFFFFFFF00002001_AD578F3A5FEEAE66);

    // full rotation: 64 reads per group, wrap to group 0 at read 256, stop at rep 15 idx 2
    bus.stage_counter = 3'd1; bus.run = 1'b1; bus.CEN = 1'b0;
    for (int c = 0; c < 319; c++) read_cycle(mdl[1][(c / 64) % 4][c % 4]);

    // pause: idx restarts, rep/grp kept so the group advances after one more sweep
    bus.run = 1'b0;
    tick();
    chk("pause_qvalid", 128'(bus.Q_valid), 128'd0);
    chk("pause_q", bus.Q, UNITY);
    tick();
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) read_cycle(mdl[1][0][i]);
    read_cycle(mdl[1][1][0]);
    read_cycle(mdl[1][1][1]);

    // stage change mid-sweep restarts at group 0 index 0 of the new stage
    bus.stage_counter = 3'd2;
    read_cycle(mdl[2][0][0]);
    read_cycle(mdl[2][0][1]);

    // load while CEN=0 is not accepted
    bus.run = 1'b0;
    load(1'b0, 0, 0, 0, HALF_LO, 64'hBAD0_BAD0_BAD0_BAD0);
    chk("err_clear", 128'(bus.err), 128'd0);

    // out-of-range load: dropped, err sticky
    bus.CEN = 1'b1;
    load(1'b0, 5, 0, 0, HALF_HI, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("err_set", 128'(bus.err), 128'd1);
    load(1'b1, 0, 0, 0, HALF_HI, 64'h0000000001000000);
    load(1'b1, 0, 0, 0, HALF_LO, 64'hFFFFF7FF00000801);
    load(1'b1, 1, 0, 0, HALF_HI, 64'h77);
    tick();
    chk("err_sticky", 128'(bus.err), 128'd1);
    chk("qconst_hold_idle", bus.Q_const, UNITY);

    bus.CEN = 1'b0; bus.run = 1'b1; bus.stage_counter = 3'd0;
    read_cycle(mdl[0][0][0]);
    chk("qconst_s0", bus.Q_const, 128'h0000000001000000_FFFFF7FF00000801);
    bus.stage_counter = 3'd1;
    read_cycle(mdl[1][0][0]);
    chk("qconst_s1", bus.Q_const, cmdl[1]);
    bus.stage_counter = 3'd5;
    tick();
    chk("oor_qvalid", 128'(bus.Q_valid), 128'd0);
    chk("oor_q", bus.Q, UNITY);
    chk("oor_qconst", bus.Q_const, cmdl[1]);

    // async reset in the middle of reading
    bus.stage_counter = 3'd1;
    read_cycle(mdl[1][0][0]);
    @(negedge CLK);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", bus.Q, UNITY);
    chk("mid_rst_qvalid", 128'(bus.Q_valid), 128'd0);
    chk("mid_rst_qconst", bus.Q_const, UNITY);
    chk("mid_rst_err", 128'(bus.err), 128'd0);
    #1 rst_n = 1'b1;
    mdl_reset();
    read_cycle(mdl[1][0][0]);

    bus.CEN = 1'b1;
    tick();
    tick();
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
